// File: rtl/kyber_ntt_wrap.sv
// Kyber NTT demo wrapper: loads r[i]=i, builds its twiddle table, runs a forward
// or inverse NTT in place, then streams the 256 coefficients out two per cycle.
module kyber_ntt_wrap (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  output logic [15:0] data_out1,
  output logic [15:0] data_out2,
  output logic        in_done,
  output logic        cal_done,
  output logic        done
);
  localparam logic [11:0] Q        = 12'd3329;
  localparam logic [11:0] ZETA     = 12'd17;
  localparam logic [11:0] ZETA_INV = 12'd1175;
  localparam logic [11:0] N_INV    = 12'd3303;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPUTE, S_SCALE, S_WAIT, S_STREAM, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  layer_q, layer_d;
  logic [11:0] p_q, p_d;
  logic        in_done_q, in_done_d, cal_done_q, cal_done_d, done_q, done_d;
  logic [11:0] out1_q, out1_d, out2_q, out2_d;

  logic [11:0] coef_mem [256];
  logic [11:0] tw_mem [128];

  function automatic logic [11:0] add_mod(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[11:0];
  endfunction

  function automatic logic [11:0] sub_mod(input logic [11:0] a, input logic [11:0] b);
    if (a >= b) return a - b;
    else return a + (Q - b);
  endfunction

  function automatic logic [6:0] bitrev7(input logic [6:0] v);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return r;
  endfunction

  // Butterfly b of the current layer: len = 2^shift, group = b/len, k = 128/len + group.
  logic [3:0]  shift;
  logic [7:0]  len_v, b_v, grp, j_lo, j_hi, k_v;
  always_comb begin
    shift = mode_q ? ({1'b0, layer_q} + 4'd1) : (4'd7 - {1'b0, layer_q});
    len_v = 8'd1 << shift;
    b_v   = {1'b0, cnt_q[6:0]};
    grp   = b_v >> shift;
    j_lo  = (grp << (shift + 4'd1)) | (b_v & (len_v - 8'd1));
    j_hi  = j_lo + len_v;
    k_v   = (8'd128 >> shift) + grp;
  end

  logic [11:0] a_v, b_val, z_v, diff_v, mul_x, mul_y, red_v;
  logic [23:0] prod_v, rem_v;
  always_comb begin
    a_v    = coef_mem[j_lo];
    b_val  = coef_mem[j_hi];
    z_v    = tw_mem[k_v[6:0]];
    diff_v = sub_mod(a_v, b_val);
    mul_x  = '0;
    mul_y  = '0;
    case (state_q)
      S_LOAD:    begin mul_x = p_q; mul_y = mode_q ? ZETA_INV : ZETA; end
      S_COMPUTE: begin mul_x = z_v; mul_y = mode_q ? diff_v : b_val; end
      S_SCALE:   begin mul_x = coef_mem[cnt_q]; mul_y = N_INV; end
      default:   ;
    endcase
    // One shared multiplier serves twiddle generation, butterflies and scaling.
    prod_v = {12'd0, mul_x} * {12'd0, mul_y};
    rem_v  = prod_v % {12'd0, Q};
    red_v  = rem_v[11:0];
  end

  logic        we0, we1, tw_we;
  logic [7:0]  wa0, wa1;
  logic [11:0] wd0, wd1, tw_wd;
  logic [6:0]  tw_wa;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    layer_d    = layer_q;
    p_d        = p_q;
    in_done_d  = in_done_q;
    cal_done_d = cal_done_q;
    done_d     = done_q;
    out1_d     = out1_q;
    out2_d     = out2_q;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    tw_we = 1'b0; tw_wa = '0; tw_wd = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          p_d     = 12'd1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        we0 = 1'b1; wa0 = cnt_q; wd0 = {4'd0, cnt_q};
        if (!cnt_q[7]) begin
          tw_we = 1'b1; tw_wa = bitrev7(cnt_q[6:0]); tw_wd = p_q;
          p_d   = red_v;
        end
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          in_done_d = 1'b1;
          layer_d   = '0;
          state_d   = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        we0 = 1'b1; wa0 = j_lo;
        we1 = 1'b1; wa1 = j_hi;
        if (mode_q) begin
          wd0 = add_mod(a_v, b_val);
          wd1 = red_v;
        end else begin
          wd0 = add_mod(a_v, red_v);
          wd1 = sub_mod(a_v, red_v);
        end
        cnt_d = {1'b0, cnt_q[6:0] + 7'd1};
        if (cnt_q[6:0] == 7'd127) begin
          layer_d = layer_q + 3'd1;
          if (layer_q == 3'd6) begin
            if (mode_q) state_d = S_SCALE;
            else begin
              cal_done_d = 1'b1;
              state_d    = S_WAIT;
            end
          end
        end
      end
      S_SCALE: begin
        we0 = 1'b1; wa0 = cnt_q; wd0 = red_v;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd255) begin
          cal_done_d = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!start) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        out1_d = coef_mem[{cnt_q[6:0], 1'b0}];
        out2_d = coef_mem[{cnt_q[6:0], 1'b1}];
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == 8'd127) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          in_done_d  = 1'b0;
          cal_done_d = 1'b0;
          done_d     = 1'b0;
          out1_d     = '0;
          out2_d     = '0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      layer_q    <= '0;
      p_q        <= '0;
      in_done_q  <= 1'b0;
      cal_done_q <= 1'b0;
      done_q     <= 1'b0;
      out1_q     <= '0;
      out2_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      layer_q    <= layer_d;
      p_q        <= p_d;
      in_done_q  <= in_done_d;
      cal_done_q <= cal_done_d;
      done_q     <= done_d;
      out1_q     <= out1_d;
      out2_q     <= out2_d;
    end
  end

  // Both butterfly writes land on distinct addresses, so two ports never collide.
  always_ff @(posedge clk) begin
    if (we0 && !rst) coef_mem[wa0] <= wd0;
    if (we1 && !rst) coef_mem[wa1] <= wd1;
    if (tw_we && !rst) tw_mem[tw_wa] <= tw_wd;
  end

  assign data_out1 = {4'd0, out1_q};
  assign data_out2 = {4'd0, out2_q};
  assign in_done   = in_done_q;
  assign cal_done  = cal_done_q;
  assign done      = done_q;
endmodule

// File: tb/tb_kyber_ntt_wrap.sv
// Testbench for kyber_ntt_wrap: compares streamed NTT/INTT results against a
// loop-level software model of the Kyber transforms on r[i] = i.
module tb_kyber_ntt_wrap;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] data_out1, data_out2;
  logic        in_done, cal_done, done;

  int checks = 0;
  int errors = 0;

  int  mr [256];
  int  expFwd [256];
  int  expInv [256];
  int  got [256];
  bit  doneAt [128];
  bit  holdDirty, orderBad, calAtDrop;

  kyber_ntt_wrap dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .data_out1(data_out1), .data_out2(data_out2),
    .in_done(in_done), .cal_done(cal_done), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int bitrev7(input int v);
    int r = 0;
    for (int i = 0; i < 7; i++) if (((v >> i) & 1) != 0) r |= (1 << (6 - i));
    return r;
  endfunction

  // Software Kyber transform of mr[] in place (forward CT or inverse GS + scale).
  task automatic model_run(input bit inv);
    int tw [128];
    int p, gen, len, z, t, a, b, base;
    p = 1;
    gen = inv ? 1175 : 17;
    for (int j = 0; j < 128; j++) begin
      tw[bitrev7(j)] = p;
      p = (p * gen) % Q;
    end
    if (!inv) begin
      for (len = 128; len >= 2; len = len / 2)
        for (int g = 0; g < 128 / len; g++) begin
          z = tw[128 / len + g];
          base = g * 2 * len;
          for (int j = base; j < base + len; j++) begin
            t = (z * mr[j + len]) % Q;
            mr[j + len] = (mr[j] - t + Q) % Q;
            mr[j] = (mr[j] + t) % Q;
          end
        end
    end else begin
      for (len = 2; len <= 128; len = len * 2)
        for (int g = 0; g < 128 / len; g++) begin
          z = tw[128 / len + g];
          base = g * 2 * len;
          for (int j = base; j < base + len; j++) begin
            a = mr[j];
            b = mr[j + len];
            mr[j] = (a + b) % Q;
            mr[j + len] = (z * ((a - b + Q) % Q)) % Q;
          end
        end
      for (int i = 0; i < 256; i++) mr[i] = (mr[i] * 3303) % Q;
    end
  endtask

  task automatic sample_order();
    if ((cal_done && !in_done) || (done && !cal_done)) orderBad = 1'b1;
  endtask

  // Drives one run from IDLE or DONE: start held for holdCycles, then released and
  // all 128 pairs captured. Optionally scrambles mode once the run is under way.
  task automatic applyStimulus(input bit md, input int holdCycles, input bit toggle);
    @(posedge clk); #1;
    mode = md;
    start = 1'b1;
    holdDirty = 1'b0;
    orderBad = 1'b0;
    for (int c = 0; c < holdCycles; c++) begin
      @(posedge clk); #1;
      if (toggle && c >= 300) mode = 1'($urandom);
      if (data_out1 != 0 || data_out2 != 0 || done) holdDirty = 1'b1;
      sample_order();
    end
    calAtDrop = cal_done;
    start = 1'b0;
    @(posedge clk); #1;
    for (int m = 0; m < 128; m++) begin
      @(posedge clk); #1;
      got[2*m]   = int'(data_out1);
      got[2*m+1] = int'(data_out2);
      doneAt[m]  = done;
      sample_order();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    checks++; if (data_out1 !== 16'd0) begin errors++; $display("[TB] FAIL reset_out1 got %0d want 0", data_out1); end
    checks++; if (data_out2 !== 16'd0) begin errors++; $display("[TB] FAIL reset_out2 got %0d want 0", data_out2); end
    checks++; if (in_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_done got %b want 0", in_done); end
    checks++; if (cal_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_cal_done got %b want 0", cal_done); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    repeat (255) @(posedge clk);
    @(negedge clk);
    checks++; if (in_done !== 1'b0) begin errors++; $display("[TB] FAIL in_done_early got %b want 0 at cycle 255", in_done); end
    @(posedge clk); @(negedge clk);
    checks++; if (in_done !== 1'b1) begin errors++; $display("[TB] FAIL in_done_timing got %b want 1 at cycle 256", in_done); end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_forward();
    mr = '{default: 0};
    for (int i = 0; i < 256; i++) mr[i] = i;
    model_run(1'b0);
    expFwd = mr;
    applyStimulus(1'b0, 3800, 1'b0);
    checks++; if (calAtDrop !== 1'b1) begin errors++; $display("[TB] FAIL fwd_cal_done got %b want 1", calAtDrop); end
    checks++; if (holdDirty !== 1'b0) begin errors++; $display("[TB] FAIL fwd_hold_quiet got %b want 0", holdDirty); end
    checks++; if (orderBad !== 1'b0) begin errors++; $display("[TB] FAIL fwd_flag_order got %b want 0", orderBad); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expFwd[i]) begin errors++; $display("[TB] FAIL fwd_coef[%0d] got %0d want %0d", i, got[i], expFwd[i]); end
      checks++; if (got[i] >= Q) begin errors++; $display("[TB] FAIL fwd_range[%0d] got %0d want < %0d", i, got[i], Q); end
    end
    for (int m = 0; m < 128; m++) begin
      checks++; if (doneAt[m] !== (m == 127)) begin errors++; $display("[TB] FAIL fwd_done[%0d] got %b want %b", m, doneAt[m], m == 127); end
    end
  endtask

  task automatic test_inverse();
    for (int i = 0; i < 256; i++) mr[i] = i;
    model_run(1'b1);
    expInv = mr;
    mr = expFwd;
    model_run(1'b1);
    for (int i = 0; i < 256; i++) begin
      checks++; if (mr[i] !== i) begin errors++; $display("[TB] FAIL model_roundtrip[%0d] got %0d want %0d", i, mr[i], i); end
    end
    applyStimulus(1'b1, 3800, 1'b0);
    checks++; if (calAtDrop !== 1'b1) begin errors++; $display("[TB] FAIL inv_cal_done got %b want 1", calAtDrop); end
    checks++; if (orderBad !== 1'b0) begin errors++; $display("[TB] FAIL inv_flag_order got %b want 0", orderBad); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expInv[i]) begin errors++; $display("[TB] FAIL inv_coef[%0d] got %0d want %0d", i, got[i], expInv[i]); end
    end
  endtask

  task automatic test_hold_restart();
    applyStimulus(1'b0, 3800, 1'b0);
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if ({in_done, cal_done, done} !== 3'b111) begin errors++; $display("[TB] FAIL done_flags got %b want 111", {in_done, cal_done, done}); end
      checks++; if (int'(data_out1) !== expFwd[254] || int'(data_out2) !== expFwd[255]) begin
        errors++; $display("[TB] FAIL done_hold got %0d/%0d want %0d/%0d", data_out1, data_out2, expFwd[254], expFwd[255]);
      end
    end
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_done, cal_done, done} !== 3'b000) begin errors++; $display("[TB] FAIL restart_flags got %b want 000", {in_done, cal_done, done}); end
    checks++; if (data_out1 !== 16'd0 || data_out2 !== 16'd0) begin errors++; $display("[TB] FAIL restart_data got %0d/%0d want 0/0", data_out1, data_out2); end
    applyStimulus(1'b0, 3800 + int'($urandom_range(0, 400)), 1'b0);
    checks++; if (holdDirty !== 1'b0) begin errors++; $display("[TB] FAIL long_hold_quiet got %b want 0", holdDirty); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expFwd[i]) begin errors++; $display("[TB] FAIL rerun_coef[%0d] got %0d want %0d", i, got[i], expFwd[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = int'($urandom_range(400, 1100));
    @(posedge clk); #1;
    mode = 1'b1; start = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    checks++; if (in_done !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre got in_done=%b done=%b want 1/0", in_done, done); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_done, cal_done, done} !== 3'b000 || data_out1 !== 16'd0 || data_out2 !== 16'd0) begin
      errors++; $display("[TB] FAIL midrst_outputs got flags=%b d1=%0d d2=%0d want 000/0/0", {in_done, cal_done, done}, data_out1, data_out2);
    end
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus(1'b1, 3800, 1'b0);
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expInv[i]) begin errors++; $display("[TB] FAIL midrst_coef[%0d] got %0d want %0d", i, got[i], expInv[i]); end
    end
  endtask

  task automatic test_mode_sampling();
    applyStimulus(1'b0, 3800, 1'b1);
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expFwd[i]) begin errors++; $display("[TB] FAIL modefwd_coef[%0d] got %0d want %0d", i, got[i], expFwd[i]); end
    end
    applyStimulus(1'b1, 3800, 1'b1);
    checks++; if (orderBad !== 1'b0) begin errors++; $display("[TB] FAIL mode_flag_order got %b want 0", orderBad); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (got[i] !== expInv[i]) begin errors++; $display("[TB] FAIL modeinv_coef[%0d] got %0d want %0d", i, got[i], expInv[i]); end
    end
  endtask

  initial begin
    $display("[TB] kyber_ntt_wrap bench starting");
    test_reset();
    test_forward();
    test_inverse();
    test_hold_restart();
    test_mid_reset();
    test_mode_sampling();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
